// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Bundles every non-clock signal of sram_arbiter: the two requester ports
// (A = CPU bus bridge, B = QSPI/co-processor DMA), the busy flag and the
// SRAM pad-side signals.
//   slave  : direction set seen by the arbiter.
//   master : direction set seen by the surrounding logic (requesters + pads).
// Requests: x_valid/x_write/x_addr/x_wdata/x_mask in, x_ready out.
// Responses: x_rsp_valid (one-cycle pulse) and x_rdata (held) out.
// b_lock: grant-lock request for port B (only honoured with SRAM_ARB_LOCK_EN).
interface sram_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic        a_write;
    logic [17:0] a_addr;
    logic [15:0] a_wdata;
    logic [1:0]  a_mask;
    logic        a_rsp_valid;
    logic [15:0] a_rdata;

    logic        b_valid;
    logic        b_ready;
    logic        b_write;
    logic [17:0] b_addr;
    logic [15:0] b_wdata;
    logic [1:0]  b_mask;
    logic        b_rsp_valid;
    logic [15:0] b_rdata;
    logic        b_lock;

    logic        busy;

    logic [17:0] io_sram_addr;
    logic [15:0] io_sram_dat_read;
    logic [15:0] io_sram_dat_write;
    logic        io_sram_dat_writeEnable;
    logic        io_sram_cs;
    logic        io_sram_we;
    logic        io_sram_oe;
    logic        io_sram_lb;
    logic        io_sram_ub;

    modport slave (
        input  a_valid, a_write, a_addr, a_wdata, a_mask,
        output a_ready, a_rsp_valid, a_rdata,
        input  b_valid, b_write, b_addr, b_wdata, b_mask, b_lock,
        output b_ready, b_rsp_valid, b_rdata,
        output busy,
        output io_sram_addr, io_sram_dat_write, io_sram_dat_writeEnable,
        output io_sram_cs, io_sram_we, io_sram_oe, io_sram_lb, io_sram_ub,
        input  io_sram_dat_read
    );

    modport master (
        output a_valid, a_write, a_addr, a_wdata, a_mask,
        input  a_ready, a_rsp_valid, a_rdata,
        output b_valid, b_write, b_addr, b_wdata, b_mask, b_lock,
        input  b_ready, b_rsp_valid, b_rdata,
        input  busy,
        input  io_sram_addr, io_sram_dat_write, io_sram_dat_writeEnable,
        input  io_sram_cs, io_sram_we, io_sram_oe, io_sram_lb, io_sram_ub,
        output io_sram_dat_read
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Sequences a 16-bit asynchronous SRAM (18-bit word address) and shares it
// between two requesters with round-robin arbitration, one access at a time.
// Each access runs IDLE -> SETUP (1) -> ACCESS (WAIT_CYCLES) -> RECOVER (1).
// All pad strobes are registered; cs/we/oe/lb/ub are active low.
// Ports:
//   io_mainClk : clock, rising edge.
//   io_reset   : synchronous active-high reset.
//   bus        : sram_arbiter_if.slave (request ports A/B, busy, SRAM pads).
// Parameter:
//   WAIT_CYCLES : cycles OE/WE is held low (1..15, 0 behaves as 1).
// Optional build macro:
//   SRAM_ARB_LOCK_EN : lets port B hold priority while b_lock stays high.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic           io_mainClk,
    input  logic           io_reset,
    sram_arbiter_if.slave  bus
);

    localparam int          WAIT_INT = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam logic [3:0]  WAIT_EFF = 4'(WAIT_INT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        wr_reg;
    logic        port_reg;
    logic        last_reg;
    logic [17:0] addr_reg;
    logic [15:0] dat_write_reg;
    logic        dat_oe_reg;
    logic        cs_reg;
    logic        we_reg;
    logic        oe_reg;
    logic        lb_reg;
    logic        ub_reg;
    logic [15:0] a_rdata_reg;
    logic [15:0] b_rdata_reg;
    logic        a_rsp_reg;
    logic        b_rsp_reg;

    logic        lock_hold;
    logic        pick_b;
    logic        idle;
    logic        sel_write;
    logic [17:0] sel_addr;
    logic [15:0] sel_wdata;
    logic [1:0]  sel_mask;

`ifdef SRAM_ARB_LOCK_EN
    logic        lock_reg;
    // Lock only stays effective while the requester keeps b_lock asserted.
    assign lock_hold = lock_reg & bus.b_lock;
`else
    logic        unused_lock;
    assign unused_lock = bus.b_lock;
    assign lock_hold   = 1'b0;
`endif

    assign idle = (state_reg == IDLE);

    // B wins when it is alone, when it holds the lock, or when A was
    // served last; otherwise A takes the slot.
    always_comb begin
        pick_b = 1'b0;
        if (bus.b_valid) begin
            pick_b = !bus.a_valid || lock_hold || (last_reg == PORT_A);
        end
    end

    assign bus.a_ready = idle & bus.a_valid & ~pick_b;
    assign bus.b_ready = idle & pick_b;

    assign sel_write = pick_b ? bus.b_write : bus.a_write;
    assign sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
    assign sel_mask  = pick_b ? bus.b_mask  : bus.a_mask;

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            wr_reg        <= 1'b0;
            port_reg      <= PORT_A;
            last_reg      <= PORT_B;
            addr_reg      <= '0;
            dat_write_reg <= '0;
            dat_oe_reg    <= 1'b0;
            cs_reg        <= 1'b1;
            we_reg        <= 1'b1;
            oe_reg        <= 1'b1;
            lb_reg        <= 1'b1;
            ub_reg        <= 1'b1;
            a_rdata_reg   <= '0;
            b_rdata_reg   <= '0;
            a_rsp_reg     <= 1'b0;
            b_rsp_reg     <= 1'b0;
`ifdef SRAM_ARB_LOCK_EN
            lock_reg      <= 1'b0;
`endif
        end else begin
            a_rsp_reg <= 1'b0;
            b_rsp_reg <= 1'b0;
`ifdef SRAM_ARB_LOCK_EN
            if (!bus.b_lock) begin
                lock_reg <= 1'b0;
            end
`endif
            case (state_reg)
                IDLE: begin
                    if (bus.a_ready || bus.b_ready) begin
                        // Pad signals are loaded here so they are already
                        // valid during the SETUP cycle.
                        port_reg  <= pick_b;
                        last_reg  <= pick_b;
                        wr_reg    <= sel_write;
                        addr_reg  <= sel_addr;
                        cs_reg    <= 1'b0;
                        if (sel_write) begin
                            lb_reg        <= ~sel_mask[0];
                            ub_reg        <= ~sel_mask[1];
                            dat_write_reg <= sel_wdata;
                            dat_oe_reg    <= 1'b1;
                        end else begin
                            lb_reg        <= 1'b0;
                            ub_reg        <= 1'b0;
                            dat_oe_reg    <= 1'b0;
                        end
`ifdef SRAM_ARB_LOCK_EN
                        if (pick_b) begin
                            lock_reg <= bus.b_lock;
                        end
`endif
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (wr_reg) begin
                        we_reg <= 1'b0;
                    end else begin
                        oe_reg <= 1'b0;
                    end
                    cnt_reg   <= WAIT_EFF - 4'd1;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        if (!wr_reg) begin
                            if (port_reg == PORT_B) begin
                                b_rdata_reg <= bus.io_sram_dat_read;
                            end else begin
                                a_rdata_reg <= bus.io_sram_dat_read;
                            end
                        end
                        cs_reg <= 1'b1;
                        we_reg <= 1'b1;
                        oe_reg <= 1'b1;
                        lb_reg <= 1'b1;
                        ub_reg <= 1'b1;
                        if (port_reg == PORT_B) begin
                            b_rsp_reg <= 1'b1;
                        end else begin
                            a_rsp_reg <= 1'b1;
                        end
                        state_reg <= RECOVER;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RECOVER: begin
                    // Write data stays driven through RECOVER for hold time.
                    dat_oe_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy                    = ~idle;
    assign bus.io_sram_addr            = addr_reg;
    assign bus.io_sram_dat_write       = dat_write_reg;
    assign bus.io_sram_dat_writeEnable = dat_oe_reg;
    assign bus.io_sram_cs              = cs_reg;
    assign bus.io_sram_we              = we_reg;
    assign bus.io_sram_oe              = oe_reg;
    assign bus.io_sram_lb              = lb_reg;
    assign bus.io_sram_ub              = ub_reg;
    assign bus.a_rdata                 = a_rdata_reg;
    assign bus.b_rdata                 = b_rdata_reg;
    assign bus.a_rsp_valid             = a_rsp_reg;
    assign bus.b_rsp_valid             = b_rsp_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Directed bench for sram_arbiter (WAIT_CYCLES = 2) with a small byte-lane
// SRAM model. Inputs change and outputs are sampled on the falling edge.
// Build with +define+SRAM_ARB_LOCK_EN to exercise the grant lock.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if bus();

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .io_mainClk (clk),
        .io_reset   (rst),
        .bus        (bus)
    );

    int tests = 0;
    int fails = 0;

    // SRAM model: 256 words are enough for the addresses used here.
    logic [15:0] mem [0:255];
    assign bus.io_sram_dat_read = mem[bus.io_sram_addr[7:0]];
    always @(posedge clk) begin
        if (!bus.io_sram_cs && !bus.io_sram_we && bus.io_sram_dat_writeEnable) begin
            if (!bus.io_sram_lb) mem[bus.io_sram_addr[7:0]][7:0]  <= bus.io_sram_dat_write[7:0];
            if (!bus.io_sram_ub) mem[bus.io_sram_addr[7:0]][15:8] <= bus.io_sram_dat_write[15:8];
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.b_lock  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        do_reset();
        #1;
        obs = {bus.io_sram_cs, bus.io_sram_we, bus.io_sram_oe, bus.io_sram_lb, bus.io_sram_ub,
               bus.io_sram_dat_writeEnable, bus.a_ready, bus.b_ready, bus.a_rsp_valid,
               bus.b_rsp_valid, bus.busy, 1'b0};
        tests++;
        if (obs !== 12'b111110000000) begin
            fails++;
            $display("FAIL reset_strobes got=%b want=%b", obs, 12'b111110000000);
        end
        tests++;
        if ({bus.io_sram_addr, bus.io_sram_dat_write, bus.a_rdata, bus.b_rdata} !== 66'd0) begin
            fails++;
            $display("FAIL reset_data addr=%h dw=%h ard=%h brd=%h", bus.io_sram_addr,
                     bus.io_sram_dat_write, bus.a_rdata, bus.b_rdata);
        end
    endtask

    // A write 0x00012 <- 0xBEEF, both lanes.
    task automatic test_write();
        logic [6:0] exp_t [1:5];
        logic [6:0] obs;
        // {cs, we, oe, writeEnable, a_rsp, b_rsp, a_ready}
        exp_t[1] = 7'b0111000;
        exp_t[2] = 7'b0011000;
        exp_t[3] = 7'b0011000;
        exp_t[4] = 7'b1111100;
        exp_t[5] = 7'b1110000;
        bus.a_write = 1'b1; bus.a_addr = 18'h00012; bus.a_wdata = 16'hBEEF; bus.a_mask = 2'b11;
        bus.a_valid = 1'b1;
        #1;
        tests++;
        if (bus.a_ready !== 1'b1) begin fails++; $display("FAIL write_ready got=%b want=1", bus.a_ready); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.a_valid = 1'b0;
            #1;
            obs = {bus.io_sram_cs, bus.io_sram_we, bus.io_sram_oe, bus.io_sram_dat_writeEnable,
                   bus.a_rsp_valid, bus.b_rsp_valid, bus.a_ready};
            tests++;
            if (obs !== exp_t[k]) begin
                fails++;
                $display("FAIL write_cycle%0d got=%b want=%b", k, obs, exp_t[k]);
            end
            if (k == 1) begin
                tests++;
                if ({bus.io_sram_addr, bus.io_sram_dat_write, bus.io_sram_lb, bus.io_sram_ub} !==
                    {18'h00012, 16'hBEEF, 2'b00}) begin
                    fails++;
                    $display("FAIL write_setup addr=%h dw=%h lb=%b ub=%b", bus.io_sram_addr,
                             bus.io_sram_dat_write, bus.io_sram_lb, bus.io_sram_ub);
                end
            end
        end
        tests++;
        if (mem[8'h12] !== 16'hBEEF) begin fails++; $display("FAIL write_mem got=%h want=beef", mem[8'h12]); end
    endtask

    // A read 0x00012, model returns 0xBEEF.
    task automatic test_read();
        logic [6:0] exp_t [1:5];
        logic [6:0] obs;
        exp_t[1] = 7'b0110000;
        exp_t[2] = 7'b0100000;
        exp_t[3] = 7'b0100000;
        exp_t[4] = 7'b1110100;
        exp_t[5] = 7'b1110000;
        bus.a_write = 1'b0; bus.a_addr = 18'h00012; bus.a_valid = 1'b1;
        #1;
        tests++;
        if (bus.a_ready !== 1'b1) begin fails++; $display("FAIL read_ready got=%b want=1", bus.a_ready); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.a_valid = 1'b0;
            #1;
            obs = {bus.io_sram_cs, bus.io_sram_we, bus.io_sram_oe, bus.io_sram_dat_writeEnable,
                   bus.a_rsp_valid, bus.b_rsp_valid, bus.a_ready};
            tests++;
            if (obs !== exp_t[k]) begin
                fails++;
                $display("FAIL read_cycle%0d got=%b want=%b", k, obs, exp_t[k]);
            end
            if (k <= 3) begin
                tests++;
                if ({bus.io_sram_lb, bus.io_sram_ub} !== 2'b00) begin
                    fails++;
                    $display("FAIL read_lanes%0d got=%b want=00", k, {bus.io_sram_lb, bus.io_sram_ub});
                end
            end else begin
                tests++;
                if (bus.a_rdata !== 16'hBEEF) begin
                    fails++;
                    $display("FAIL read_rdata%0d got=%h want=beef", k, bus.a_rdata);
                end
            end
        end
    endtask

    // B write 0x1234 with only the low lane enabled.
    task automatic test_byte_mask();
        logic [3:0] obs;
        bus.b_write = 1'b1; bus.b_addr = 18'h00012; bus.b_wdata = 16'h1234; bus.b_mask = 2'b01;
        bus.b_valid = 1'b1;
        #1;
        tests++;
        if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
            fails++;
            $display("FAIL mask_ready got=%b want=01", {bus.a_ready, bus.b_ready});
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.b_valid = 1'b0;
            #1;
            obs = {bus.io_sram_lb, bus.io_sram_ub, bus.a_rsp_valid, bus.b_rsp_valid};
            tests++;
            if (obs !== ((k <= 3) ? 4'b0100 : (k == 4) ? 4'b1101 : 4'b1100)) begin
                fails++;
                $display("FAIL mask_cycle%0d got=%b", k, obs);
            end
        end
        tests++;
        if (mem[8'h12] !== 16'hBE34) begin fails++; $display("FAIL mask_mem got=%h want=be34", mem[8'h12]); end
    endtask

    // Mask 00 write: full cycle with both lanes off, still a response.
    task automatic test_mask_zero();
        logic [2:0] obs;
        bus.a_write = 1'b1; bus.a_addr = 18'h00012; bus.a_wdata = 16'h0000; bus.a_mask = 2'b00;
        bus.a_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.a_valid = 1'b0;
            #1;
            obs = {bus.io_sram_lb, bus.io_sram_ub, bus.a_rsp_valid};
            tests++;
            if (obs !== ((k == 4) ? 3'b111 : 3'b110)) begin
                fails++;
                $display("FAIL mask0_cycle%0d got=%b", k, obs);
            end
        end
        tests++;
        if (mem[8'h12] !== 16'hBE34) begin fails++; $display("FAIL mask0_mem got=%h want=be34", mem[8'h12]); end
    endtask

    // Reset during ACCESS of an A read drops the access.
    task automatic test_reset_mid();
        logic [5:0] obs;
        bus.a_write = 1'b0; bus.a_addr = 18'h00012; bus.a_valid = 1'b1;
        @(negedge clk);
        bus.a_valid = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (bus.io_sram_oe !== 1'b0) begin fails++; $display("FAIL rstmid_access oe=%b want=0", bus.io_sram_oe); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        obs = {bus.io_sram_cs, bus.io_sram_we, bus.io_sram_oe, bus.io_sram_dat_writeEnable,
               bus.a_rsp_valid, bus.busy};
        tests++;
        if (obs !== 6'b111000) begin fails++; $display("FAIL rstmid_forced got=%b want=111000", obs); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (bus.a_rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_norsp got=1 want=0"); end
        end
        bus.a_valid = 1'b1;
        #1;
        tests++;
        if (bus.a_ready !== 1'b1) begin fails++; $display("FAIL rstmid_reaccept got=%b want=1", bus.a_ready); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.a_valid = 1'b0;
            #1;
            if (k == 4) begin
                tests++;
                if ({bus.a_rsp_valid, bus.a_rdata} !== {1'b1, 16'hBE34}) begin
                    fails++;
                    $display("FAIL rstmid_rsp rsp=%b rdata=%h want 1/be34", bus.a_rsp_valid, bus.a_rdata);
                end
            end
        end
    endtask

    // Both ports held valid after reset: A, B, A, B.
    task automatic test_round_robin();
        int grants = 0, rsps = 0, cur = -1, last_t = 0, port;
        do_reset();
        bus.a_write = 1'b0; bus.a_addr = 18'h00001;
        bus.b_write = 1'b0; bus.b_addr = 18'h00002;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && rsps < 4; cyc++) begin
            if (grants == 4) begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; end
            #1;
            if (bus.a_ready && bus.b_ready) begin fails++; $display("FAIL rr_double_ready cyc=%0d", cyc); end
            if (bus.a_ready || bus.b_ready) begin
                port = bus.b_ready ? 1 : 0;
                tests++;
                if (port != grants % 2) begin
                    fails++;
                    $display("FAIL rr_grant%0d got=%0d want=%0d", grants, port, grants % 2);
                end
                if (grants > 0) begin
                    tests++;
                    if (cyc - last_t != 5) begin
                        fails++;
                        $display("FAIL rr_spacing%0d got=%0d want=5", grants, cyc - last_t);
                    end
                end
                last_t = cyc; cur = port; grants++;
            end
            if (bus.a_rsp_valid) begin
                tests++; rsps++;
                if (cur != 0) begin fails++; $display("FAIL rr_rsp_port got=A want=%0d", cur); end
            end
            if (bus.b_rsp_valid) begin
                tests++; rsps++;
                if (cur != 1) begin fails++; $display("FAIL rr_rsp_port got=B want=%0d", cur); end
            end
            @(negedge clk);
        end
        tests++;
        if (grants != 4 || rsps != 4) begin
            fails++;
            $display("FAIL rr_timeout grants=%0d rsps=%0d want 4/4", grants, rsps);
        end
    endtask

    // b_lock held with both ports busy; dropped after the fourth grant.
    task automatic test_lock();
        int exp_p [0:4];
        int grants = 0, port;
`ifdef SRAM_ARB_LOCK_EN
        exp_p = '{0, 1, 1, 1, 0};
`else
        exp_p = '{0, 1, 0, 1, 0};
`endif
        do_reset();
        bus.a_write = 1'b0; bus.b_write = 1'b0;
        bus.b_lock = 1'b1;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && grants < 5; cyc++) begin
            if (grants == 4) bus.b_lock = 1'b0;
            #1;
            if (bus.a_ready || bus.b_ready) begin
                port = bus.b_ready ? 1 : 0;
                tests++;
                if (port != exp_p[grants]) begin
                    fails++;
                    $display("FAIL lock_grant%0d got=%0d want=%0d", grants, port, exp_p[grants]);
                end
                grants++;
            end
            @(negedge clk);
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        tests++;
        if (grants != 5) begin fails++; $display("FAIL lock_timeout grants=%0d want=5", grants); end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        bus.a_valid = 1'b0; bus.a_write = 1'b0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_mask = '0;
        bus.b_valid = 1'b0; bus.b_write = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_mask = '0;
        bus.b_lock  = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_byte_mask();
        test_mask_zero();
        test_reset_mid();
        test_round_robin();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the board's external 16-bit asynchronous SRAM (18-bit word address) and shares it between two requesters.
  - Port A: CPU-side bus bridge.
  - Port B: QSPI/co-processor DMA path.
- Generates all SRAM strobes, including the data-pin output enable, with fixed setup, access and recovery phases.
- Sits between the SoC bus logic and the SRAM pad cells.
- Arbitrates round-robin, one access at a time.

Parameters:
- WAIT_CYCLES, 2: cycles the OE or WE strobe is held low per access. Legal range 1..15; a value of 0 behaves as 1.

Ports:
- io_mainClk  in  1  system clock; all logic on the rising edge.
- io_reset  in  1  synchronous, active-high reset.
- a_valid  in  1  port A request; held with its payload until accepted.
- a_ready  out  1  port A request accepted this cycle.
- a_write  in  1  1 = write, 0 = read.
- a_addr  in  18  word address.
- a_wdata  in  16  write data.
- a_mask  in  2  byte enables for writes: bit0 = low byte, bit1 = high byte.
- a_rsp_valid  out  1  one-cycle completion pulse.
- a_rdata  out  16  read data; valid while a_rsp_valid=1 and held afterwards.
- b_valid, b_ready, b_write, b_addr, b_wdata, b_mask, b_rsp_valid, b_rdata: same as port A, for port B.
- b_lock  in  1  grant lock request; used only with SRAM_ARB_LOCK_EN.
- busy  out  1  high whenever the FSM is not IDLE.
- io_sram_addr  out  18  SRAM address.
- io_sram_dat_read  in  16  data from the pads.
- io_sram_dat_write  out  16  data to the pads.
- io_sram_dat_writeEnable  out  1  pad output enable.
- io_sram_cs, io_sram_we, io_sram_oe, io_sram_lb, io_sram_ub  out  1 each  SRAM strobes, all active low.

Behaviour:
- Reset values:
  - io_sram_cs, we, oe, lb, ub = 1.
  - io_sram_writeEnable = 0; io_sram_addr = 0; io_sram_dat_write = 0.
  - a_rdata, b_rdata = 0; all ready and rsp_valid outputs = 0.
  - FSM = IDLE; last-served = B, so A wins the first conflict.
- Reset mid-access: the next edge forces the reset values. The in-flight access is dropped with no rsp pulse; the requester reissues.
- FSM states: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> RECOVER -> IDLE.
- IDLE:
  - x_ready is combinational and asserts only in IDLE, for the selected port.
  - Only A valid -> A. Only B valid -> B. Both valid -> the port not last-served.
  - On acceptance the controller registers write, addr, wdata, mask and port id, and updates last-served.
  - Requesters must not make valid depend on ready.
- SETUP (1 cycle):
  - cs=0; io_sram_addr = captured address.
  - Write: lb = ~mask[0], ub = ~mask[1]; dat_write = wdata; writeEnable = 1.
  - Read: lb = ub = 0; writeEnable = 0.
  - oe and we stay 1.
- ACCESS (WAIT_CYCLES cycles, down-counter): read drives oe=0; write drives we=0. Address, data and byte lanes stay stable.
- Last ACCESS cycle of a read: io_sram_dat_read is registered into the granted port's rdata.
- RECOVER (1 cycle):
  - cs, we, oe, lb and ub return to 1.
  - Writes keep writeEnable=1 and data driven this cycle (hold time); writeEnable drops on entry to IDLE.
  - The granted port's rsp_valid = 1 for exactly this cycle, for reads and writes.
  - A write leaves rdata unchanged.
- Latency: accept at cycle T, rsp_valid at T+2+WAIT_CYCLES, next accept no earlier than T+3+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Write with mask = 00: full cycle is run with lb = ub = 1, so memory is unchanged; it still gets an rsp pulse.
- A request arriving during SETUP, ACCESS or RECOVER waits; ready stays 0.
- No starvation: under continuous requests on both ports, grants alternate A, B, A, B.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- With the macro defined:
  - If b_lock=1 when B is accepted, B keeps priority in IDLE while b_lock stays 1: B is granted whenever b_valid=1, even if A is waiting.
  - Dropping b_lock restores round-robin. The next conflict goes to A.
- Without the macro: b_lock is ignored and arbitration is pure round-robin.

Test Plan:
- Reset, then A write addr=0x00012, wdata=0xBEEF, mask=11, WAIT_CYCLES=2 -> a_ready at T; cs=0 from T+1 to T+3; we=0 at T+2..T+3; writeEnable=1 at T+1..T+4; a_rsp_valid only at T+4.
- A read of 0x00012 with the SRAM model returning 0xBEEF -> oe=0 for 2 cycles, lb=ub=0, a_rdata=0xBEEF at the rsp pulse and held afterwards.
- A and B assert valid in the same cycle, both held continuously for 4 accesses -> grant order A, B, A, B; each rsp pulse appears only on the granted port.
- B write wdata=0x1234, mask=01 -> lb=0, ub=1 during SETUP and ACCESS; the SRAM model's high byte is unchanged.
- io_reset asserted during ACCESS of an A read -> next edge cs=we=oe=1 and writeEnable=0; no a_rsp_valid; a fresh request is accepted from IDLE afterwards.
- SRAM_ARB_LOCK_EN defined, b_lock=1, both ports valid continuously -> 3 consecutive B grants; b_lock dropped -> next grant is A.
